// File: rtl/ntt_issue_pkg.sv
// rtl/ntt_issue_pkg.sv - shared types, constants and bank mapping for the radix-4 issue controller
package ntt_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } issue_state_t;

  localparam int N_LOG4  = 4;
  localparam int N_BANKS = 4;
  localparam int BANK_AW = 6;

  localparam logic [7:0] TW_INTT_OFS = 8'd85;
  localparam logic [7:0] TW_STAGE_OFS [N_LOG4] = '{8'd0, 8'd1, 8'd5, 8'd21};

  typedef struct packed {
    logic               en;
    logic [1:0]         rot;
    logic [BANK_AW-1:0] a3;
    logic [BANK_AW-1:0] a2;
    logic [BANK_AW-1:0] a1;
    logic [BANK_AW-1:0] a0;
  } wb_entry_t;

  // Digit-sum mod 4: the 2-bit adder wrap performs the modulo.
  function automatic logic [1:0] bank_of(input logic [7:0] i);
    return i[1:0] + i[3:2] + i[5:4] + i[7:6];
  endfunction

endpackage

// File: rtl/bank_rotate.sv
// rtl/bank_rotate.sv - 4-lane rotate-by-rot crossbar: out_k = in_((k+rot) mod 4)
module bank_rotate
  import ntt_issue_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [1:0]   rot,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3
);

  logic [W-1:0] lane [N_BANKS];

  assign lane[0] = in0;
  assign lane[1] = in1;
  assign lane[2] = in2;
  assign lane[3] = in3;

  assign out0 = lane[rot];
  assign out1 = lane[rot + 2'd1];
  assign out2 = lane[rot + 2'd2];
  assign out3 = lane[rot + 2'd3];

endmodule

// File: rtl/radix4_bf_issue.sv
// rtl/radix4_bf_issue.sv - radix-4 butterfly issue/writeback sequencer for 256-point NTT/INTT
// BF_ISSUE_HOLD_EN adds a hold input that stalls issue while the pipelines keep draining.
module radix4_bf_issue
  import ntt_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int BF_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
`ifdef BF_ISSUE_HOLD_EN
  input  logic                  hold,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [BANK_AW-1:0]    rd_addr0,
  output logic [BANK_AW-1:0]    rd_addr1,
  output logic [BANK_AW-1:0]    rd_addr2,
  output logic [BANK_AW-1:0]    rd_addr3,
  input  logic [DATA_WIDTH-1:0] rd_data0,
  input  logic [DATA_WIDTH-1:0] rd_data1,
  input  logic [DATA_WIDTH-1:0] rd_data2,
  input  logic [DATA_WIDTH-1:0] rd_data3,
  output logic [7:0]            tw_addr,
  input  logic [DATA_WIDTH-1:0] tw_data1,
  input  logic [DATA_WIDTH-1:0] tw_data2,
  input  logic [DATA_WIDTH-1:0] tw_data3,
  output logic                  bf_valid,
  output logic [DATA_WIDTH-1:0] u0,
  output logic [DATA_WIDTH-1:0] v0,
  output logic [DATA_WIDTH-1:0] u1,
  output logic [DATA_WIDTH-1:0] v1,
  output logic [DATA_WIDTH-1:0] wa1,
  output logic [DATA_WIDTH-1:0] wa2,
  output logic [DATA_WIDTH-1:0] wa3,
  output logic                  sel,
  output logic                  wb_en,
  output logic [BANK_AW-1:0]    wb_addr0,
  output logic [BANK_AW-1:0]    wb_addr1,
  output logic [BANK_AW-1:0]    wb_addr2,
  output logic [BANK_AW-1:0]    wb_addr3,
  output logic [1:0]            wb_rot
);

  localparam int         WB_DEPTH   = BF_LAT + 2;
  localparam logic [7:0] DRAIN_LAST = 8'(BF_LAT + 1);

  issue_state_t state_q, state_n;
  logic [1:0]   stage_q;
  logic [5:0]   j_q;
  logic [7:0]   drain_q;
  logic         mode_q;
  logic         hold_w;
  logic         issue;

`ifdef BF_ISSUE_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  assign issue = (state_q == ST_ISSUE) && !hold_w;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_FIN);
  assign sel   = mode_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_n = ST_ISSUE;
      ST_ISSUE: if (issue && j_q == 6'd63) state_n = ST_DRAIN;
      ST_DRAIN: if (drain_q == DRAIN_LAST)
                  state_n = (stage_q == 2'(N_LOG4 - 1)) ? ST_FIN : ST_ISSUE;
      ST_FIN:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= 2'd0;
      j_q     <= 6'd0;
      drain_q <= 8'd0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          stage_q <= 2'd0;
          j_q     <= 6'd0;
          drain_q <= 8'd0;
          mode_q  <= mode;
        end
        ST_ISSUE: if (issue) j_q <= j_q + 6'd1;
        ST_DRAIN: if (drain_q == DRAIN_LAST) begin
          drain_q <= 8'd0;
          stage_q <= stage_q + 2'd1;
        end else begin
          drain_q <= drain_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Index generation: stride is 4^lg, so all divides and multiplies become shifts.
  logic [2:0]         sh;
  logic [7:0]         stride, offset, base, tw_calc;
  logic [5:0]         group;
  logic [1:0]         r;
  logic [7:0]         idx  [N_BANKS];
  logic [BANK_AW-1:0] rd_a [N_BANKS];

  always_comb begin
    sh      = mode_q ? {stage_q, 1'b0} : {2'd3 - stage_q, 1'b0};
    stride  = 8'd1 << sh;
    group   = j_q >> sh;
    offset  = {2'b00, j_q} & (stride - 8'd1);
    base    = (({2'b00, group} << sh) << 2) | offset;
    idx[0]  = base;
    idx[1]  = base + stride;
    idx[2]  = base + {stride[6:0], 1'b0};
    idx[3]  = idx[2] + stride;
    r       = bank_of(base);
    for (int b = 0; b < N_BANKS; b++) rd_a[b] = 6'(idx[2'(b) - r] >> 2);
    tw_calc = (mode_q ? TW_INTT_OFS : 8'd0) + TW_STAGE_OFS[stage_q] + {2'b00, group};
  end

  assign rd_en    = issue;
  assign rd_addr0 = issue ? rd_a[0] : '0;
  assign rd_addr1 = issue ? rd_a[1] : '0;
  assign rd_addr2 = issue ? rd_a[2] : '0;
  assign rd_addr3 = issue ? rd_a[3] : '0;
  assign tw_addr  = issue ? tw_calc : 8'd0;

  logic                  v1_q;
  logic [1:0]            r1_q;
  logic [DATA_WIDTH-1:0] x0, x1, x2, x3;

  bank_rotate #(.W(DATA_WIDTH)) u_rot (
    .rot  (r1_q),
    .in0  (rd_data0),
    .in1  (rd_data1),
    .in2  (rd_data2),
    .in3  (rd_data3),
    .out0 (x0),
    .out1 (x1),
    .out2 (x2),
    .out3 (x3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      r1_q     <= 2'd0;
      bf_valid <= 1'b0;
      u0       <= '0;
      v0       <= '0;
      u1       <= '0;
      v1       <= '0;
      wa1      <= '0;
      wa2      <= '0;
      wa3      <= '0;
    end else begin
      v1_q     <= issue;
      r1_q     <= issue ? r : 2'd0;
      bf_valid <= v1_q;
      if (v1_q) begin
        u0  <= x0;
        v0  <= x1;
        u1  <= x2;
        v1  <= x3;
        wa1 <= tw_data1;
        wa2 <= tw_data2;
        wa3 <= tw_data3;
      end
    end
  end

  // Writeback reuses the read addresses (in-place), delayed to meet the butterfly output.
  wb_entry_t wb_cur;
  wb_entry_t wb_pipe [WB_DEPTH];

  always_comb begin
    wb_cur    = '0;
    wb_cur.en = issue;
    if (issue) begin
      wb_cur.rot = r;
      wb_cur.a0  = rd_a[0];
      wb_cur.a1  = rd_a[1];
      wb_cur.a2  = rd_a[2];
      wb_cur.a3  = rd_a[3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WB_DEPTH; i++) wb_pipe[i] <= '0;
    end else begin
      wb_pipe[0] <= wb_cur;
      for (int i = 1; i < WB_DEPTH; i++) wb_pipe[i] <= wb_pipe[i-1];
    end
  end

  assign wb_en    = wb_pipe[WB_DEPTH-1].en;
  assign wb_rot   = wb_pipe[WB_DEPTH-1].rot;
  assign wb_addr0 = wb_pipe[WB_DEPTH-1].a0;
  assign wb_addr1 = wb_pipe[WB_DEPTH-1].a1;
  assign wb_addr2 = wb_pipe[WB_DEPTH-1].a2;
  assign wb_addr3 = wb_pipe[WB_DEPTH-1].a3;

endmodule

// File: tb/tb_radix4_bf_issue.sv
// tb/tb_radix4_bf_issue.sv - directed self-checking bench for radix4_bf_issue
module tb_radix4_bf_issue;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst, start, mode;
`ifdef BF_ISSUE_HOLD_EN
  logic          hold = 1'b0;
`endif
  logic          busy, done, rd_en, bf_valid, sel, wb_en;
  logic [5:0]    rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [5:0]    wb_addr0, wb_addr1, wb_addr2, wb_addr3;
  logic [DW-1:0] rd_data0 = '0, rd_data1 = '0, rd_data2 = '0, rd_data3 = '0;
  logic [DW-1:0] tw_data1 = '0, tw_data2 = '0, tw_data3 = '0;
  logic [7:0]    tw_addr;
  logic [DW-1:0] u0, v0, u1, v1, wa1, wa2, wa3;
  logic [1:0]    wb_rot;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  radix4_bf_issue #(.DATA_WIDTH(DW), .BF_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef BF_ISSUE_HOLD_EN
    .hold(hold),
`endif
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .tw_addr(tw_addr), .tw_data1(tw_data1), .tw_data2(tw_data2), .tw_data3(tw_data3),
    .bf_valid(bf_valid), .u0(u0), .v0(v0), .u1(u1), .v1(v1),
    .wa1(wa1), .wa2(wa2), .wa3(wa3), .sel(sel), .wb_en(wb_en),
    .wb_addr0(wb_addr0), .wb_addr1(wb_addr1), .wb_addr2(wb_addr2), .wb_addr3(wb_addr3),
    .wb_rot(wb_rot)
  );

  task automatic expect_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] bank_val(input int b, input int a);
    return DW'(b * 1024 + a * 8 + 3);
  endfunction

  function automatic logic [DW-1:0] tw_val(input int k, input int a);
    return DW'(k * 4096 + a);
  endfunction

  // Bank and twiddle ROM model: one-cycle read latency.
  logic       m_en;
  logic [5:0] m_a0, m_a1, m_a2, m_a3;
  logic [7:0] m_tw;
  always begin
    @(negedge clk);
    m_en = rd_en;
    m_a0 = rd_addr0; m_a1 = rd_addr1; m_a2 = rd_addr2; m_a3 = rd_addr3;
    m_tw = tw_addr;
    @(posedge clk);
    #1;
    if (m_en) begin
      rd_data0 = bank_val(0, m_a0);
      rd_data1 = bank_val(1, m_a1);
      rd_data2 = bank_val(2, m_a2);
      rd_data3 = bank_val(3, m_a3);
    end
    tw_data1 = tw_val(1, m_tw);
    tw_data2 = tw_val(2, m_tw);
    tw_data3 = tw_val(3, m_tw);
  end

  initial begin
    int busy_n, done_n, rd_n, wb_n, sel_bad;
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_done", done, 0);
    expect_eq("rst_rd_en", rd_en, 0);
    expect_eq("rst_bf_valid", bf_valid, 0);
    expect_eq("rst_wb_en", wb_en, 0);
    expect_eq("rst_rd_addr1", rd_addr1, 0);
    expect_eq("rst_tw_addr", tw_addr, 0);
    expect_eq("rst_u0", u0, 0);
    expect_eq("rst_wb_rot", wb_rot, 0);
    expect_eq("rst_sel", sel, 0);
    rst = 1'b0;

    // Full NTT run with a stray start/mode pulse in the middle
    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    busy_n = 0; done_n = 0; rd_n = 0; wb_n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy)  busy_n++;
      if (done)  done_n++;
      if (rd_en) rd_n++;
      if (wb_en) wb_n++;
      case (k)
        0: begin
          expect_eq("ntt_j0_rd_en", rd_en, 1);
          expect_eq("ntt_j0_a0", rd_addr0, 0);
          expect_eq("ntt_j0_a1", rd_addr1, 16);
          expect_eq("ntt_j0_a2", rd_addr2, 32);
          expect_eq("ntt_j0_a3", rd_addr3, 48);
          expect_eq("ntt_j0_tw", tw_addr, 0);
        end
        1: begin
          expect_eq("ntt_j1_a0", rd_addr0, 48);
          expect_eq("ntt_j1_a1", rd_addr1, 0);
          expect_eq("ntt_j1_a2", rd_addr2, 16);
          expect_eq("ntt_j1_a3", rd_addr3, 32);
          expect_eq("ntt_bfv_early", bf_valid, 0);
        end
        2: begin
          expect_eq("ntt_j0_bfv", bf_valid, 1);
          expect_eq("ntt_j0_u0", u0, bank_val(0, 0));
          expect_eq("ntt_j0_v0", v0, bank_val(1, 16));
          expect_eq("ntt_j0_u1", u1, bank_val(2, 32));
          expect_eq("ntt_j0_v1", v1, bank_val(3, 48));
          expect_eq("ntt_j0_wa1", wa1, tw_val(1, 0));
          expect_eq("ntt_j0_wa3", wa3, tw_val(3, 0));
        end
        3: begin
          expect_eq("ntt_j1_u0", u0, bank_val(1, 0));
          expect_eq("ntt_j1_v1", v1, bank_val(0, 48));
        end
        4: expect_eq("ntt_wb_early", wb_en, 0);
        5: begin
          expect_eq("ntt_j0_wb_en", wb_en, 1);
          expect_eq("ntt_j0_wb_a1", wb_addr1, 16);
          expect_eq("ntt_j0_wb_rot", wb_rot, 0);
        end
        100: expect_eq("ntt_sel_kept", sel, 0);
        212: begin
          expect_eq("ntt_s3j5_a0", rd_addr0, 5);
          expect_eq("ntt_s3j5_a1", rd_addr1, 5);
          expect_eq("ntt_s3j5_a3", rd_addr3, 5);
          expect_eq("ntt_s3j5_tw", tw_addr, 26);
        end
        217: begin
          expect_eq("ntt_s3j5_wb_en", wb_en, 1);
          expect_eq("ntt_s3j5_wb_rot", wb_rot, 2);
          expect_eq("ntt_s3j5_wb_a2", wb_addr2, 5);
        end
        276: expect_eq("ntt_done_cycle", done, 1);
        default: ;
      endcase
      if (k == 50) begin start = 1'b1; mode = 1'b1; end
      if (k == 51) begin start = 1'b0; mode = 1'b0; end
    end
    expect_eq("ntt_busy_cycles", busy_n, 277);
    expect_eq("ntt_done_pulses", done_n, 1);
    expect_eq("ntt_rd_cycles", rd_n, 256);
    expect_eq("ntt_wb_cycles", wb_n, 256);

    // Full INTT run; mode is dropped right after start to show it is latched
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    busy_n = 0; sel_bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) begin start = 1'b0; mode = 1'b0; end
      if (busy) busy_n++;
      if (busy && !sel) sel_bad++;
      case (k)
        0: begin
          expect_eq("intt_j0_tw", tw_addr, 85);
          expect_eq("intt_j0_a3", rd_addr3, 0);
        end
        1: begin
          expect_eq("intt_j1_a2", rd_addr2, 1);
          expect_eq("intt_j1_tw", tw_addr, 86);
        end
        2: begin
          expect_eq("intt_j0_u0", u0, bank_val(0, 0));
          expect_eq("intt_j0_v1", v1, bank_val(3, 0));
        end
        3: begin
          expect_eq("intt_j1_u0", u0, bank_val(1, 1));
          expect_eq("intt_j1_v1", v1, bank_val(0, 1));
        end
        207: expect_eq("intt_s3_tw", tw_addr, 106);
        default: ;
      endcase
    end
    expect_eq("intt_busy_cycles", busy_n, 277);
    expect_eq("intt_sel_low_cycles", sel_bad, 0);

    // Reset mid-run, then restart as NTT
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k == 0) begin start = 1'b0; mode = 1'b0; end
    end
    rst = 1'b1;
    @(negedge clk);
    expect_eq("mid_rst_busy", busy, 0);
    expect_eq("mid_rst_done", done, 0);
    expect_eq("mid_rst_rd_en", rd_en, 0);
    expect_eq("mid_rst_bfv", bf_valid, 0);
    expect_eq("mid_rst_wb_en", wb_en, 0);
    expect_eq("mid_rst_u0", u0, 0);
    expect_eq("mid_rst_wa1", wa1, 0);
    expect_eq("mid_rst_wb_a0", wb_addr0, 0);
    expect_eq("mid_rst_wb_rot", wb_rot, 0);
    expect_eq("mid_rst_rd_a1", rd_addr1, 0);
    expect_eq("mid_rst_tw", tw_addr, 0);
    expect_eq("mid_rst_sel", sel, 0);
    rst = 1'b0;
    @(negedge clk);
    expect_eq("post_rst_idle_busy", busy, 0);
    expect_eq("post_rst_idle_rd_en", rd_en, 0);
    start = 1'b1; mode = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      case (k)
        0: expect_eq("re_j0_a1", rd_addr1, 16);
        1: expect_eq("re_j1_a0", rd_addr0, 48);
        2: begin
          expect_eq("re_j0_bfv", bf_valid, 1);
          expect_eq("re_j0_u0", u0, bank_val(0, 0));
        end
        5: begin
          expect_eq("re_j0_wb_en", wb_en, 1);
          expect_eq("re_j0_wb_a3", wb_addr3, 48);
        end
        default: ;
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
